// File: rtl/cpu_mon_pkg.sv
// Shared definitions for the CPU run monitor: FSM encodings and default MISR polynomial.
package cpu_mon_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HOLD = 2'd1,
    ST_RUN  = 2'd2,
    ST_DONE = 2'd3
  } mon_state_e;

  localparam logic [31:0] DEFAULT_POLY = 32'h04C11DB7;

endpackage

// File: rtl/cpu_run_monitor_misr.sv
// Multiple-input signature register folding all valid channels into one DW-bit signature.
module misr
  import cpu_mon_pkg::*;
#(
  parameter int             DW   = 32,
  parameter int             NCH  = 3,
  parameter logic [DW-1:0]  POLY = DW'(DEFAULT_POLY)
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              clear,
  input  logic              en,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_valid,
  output logic [DW-1:0]     signature
);

  logic [DW-1:0] fold;
  logic [DW-1:0] sig_next;

  // XOR of every enabled channel, then shift with polynomial feedback
  always_comb begin
    fold = {DW{1'b0}};
    for (int i = 0; i < NCH; i++) begin
      if (ch_valid[i]) begin
        fold = fold ^ ch_data[i*DW +: DW];
      end else begin
        fold = fold;
      end
    end
    sig_next = (signature << 1) ^ (signature[DW-1] ? POLY : {DW{1'b0}}) ^ fold;
  end

  // signature register; Clrn wins over a restart clear, which wins over update
  always_ff @(posedge Clk) begin
    if (Clrn) begin
      signature <= {DW{1'b0}};
    end else if (clear) begin
      signature <= {DW{1'b0}};
    end else if (en) begin
      signature <= sig_next;
    end else begin
      signature <= signature;
    end
  end

endmodule

// File: rtl/cpu_run_monitor.sv
// Run monitor: holds the CPU in reset, lets it run, detects halt or timeout and signs its buses.
module cpu_run_monitor
  import cpu_mon_pkg::*;
#(
  parameter int            DW          = 32,
  parameter int            NCH         = 3,
  parameter int            RST_CYCLES  = 2,
  parameter int            MAX_CYCLES  = 20,
  parameter int            HALT_REPEAT = 2,
  parameter logic [DW-1:0] POLY        = DW'(DEFAULT_POLY)
) (
  input  logic              Clk,
  input  logic              Clrn,
  input  logic              start,
  input  logic [DW-1:0]     pc,
  input  logic [NCH*DW-1:0] ch_data,
  input  logic [NCH-1:0]    ch_valid,
  output logic              cpu_clrn,
  output logic [1:0]        state,
  output logic [15:0]       cycles,
  output logic [DW-1:0]     signature,
  output logic              done,
  output logic              halted,
  output logic              timeout
);

  localparam logic [15:0] RST_LAST = 16'((RST_CYCLES > 0) ? (RST_CYCLES - 1) : 0);
  localparam logic [15:0] MAX_C    = 16'(MAX_CYCLES);
  localparam logic [15:0] HALT_N   = 16'(HALT_REPEAT);

  mon_state_e    st;
  logic [15:0]   hold_cnt;
  logic [15:0]   halt_cnt;
  logic [DW-1:0] prev_pc;
  logic          run_seen;

  logic [15:0]   cyc_inc;
  logic [15:0]   halt_inc;
  logic          pc_match;
  logic          hit_halt;
  logic          hit_time;
  logic          restart;

  assign state = st;

  // next-cycle counters and the two run-ending conditions
  always_comb begin
    cyc_inc  = (cycles == 16'hFFFF) ? cycles : (cycles + 16'd1);
    pc_match = run_seen && (pc == prev_pc);
    halt_inc = pc_match ? (halt_cnt + 16'd1) : 16'd0;
    hit_halt = (halt_inc >= HALT_N);
    hit_time = (cyc_inc >= MAX_C);
    restart  = ((st == ST_IDLE) || (st == ST_DONE)) && start;
  end

  // run-control FSM with registered status outputs
  always_ff @(posedge Clk) begin
    if (Clrn) begin
      st       <= ST_IDLE;
      cpu_clrn <= 1'b0;
      cycles   <= 16'd0;
      done     <= 1'b0;
      halted   <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= 16'd0;
      halt_cnt <= 16'd0;
      prev_pc  <= {DW{1'b0}};
      run_seen <= 1'b0;
    end else begin
      case (st)
        ST_IDLE, ST_DONE: begin
          if (restart) begin
            st       <= ST_HOLD;
            cycles   <= 16'd0;
            done     <= 1'b0;
            halted   <= 1'b0;
            timeout  <= 1'b0;
            hold_cnt <= 16'd0;
            halt_cnt <= 16'd0;
            run_seen <= 1'b0;
          end else begin
            st <= st;
          end
        end
        ST_HOLD: begin
          if (hold_cnt >= RST_LAST) begin
            st       <= ST_RUN;
            cpu_clrn <= 1'b1;
          end else begin
            hold_cnt <= hold_cnt + 16'd1;
          end
        end
        ST_RUN: begin
          cycles   <= cyc_inc;
          prev_pc  <= pc;
          run_seen <= 1'b1;
          halt_cnt <= halt_inc;
          // halt outranks a simultaneous timeout
          if (hit_halt) begin
            st       <= ST_DONE;
            cpu_clrn <= 1'b0;
            done     <= 1'b1;
            halted   <= 1'b1;
          end else if (hit_time) begin
            st       <= ST_DONE;
            cpu_clrn <= 1'b0;
            done     <= 1'b1;
            timeout  <= 1'b1;
          end else begin
            st <= ST_RUN;
          end
        end
        default: begin
          st       <= ST_IDLE;
          cpu_clrn <= 1'b0;
        end
      endcase
    end
  end

  misr #(
    .DW   (DW),
    .NCH  (NCH),
    .POLY (POLY)
  ) u_misr (
    .Clk       (Clk),
    .Clrn      (Clrn),
    .clear     (restart),
    .en        (st == ST_RUN),
    .ch_data   (ch_data),
    .ch_valid  (ch_valid),
    .signature (signature)
  );

endmodule

// File: tb/tb_cpu_run_monitor.sv
// Scoreboard bench for cpu_run_monitor: stimulus queues expectations, a negedge monitor checks them.
module tb_cpu_run_monitor;

  localparam int DW  = 32;
  localparam int NCH = 3;

  logic              Clk = 1'b0;
  logic              Clrn;
  logic              start;
  logic [DW-1:0]     pc;
  logic [NCH*DW-1:0] ch_data;
  logic [NCH-1:0]    ch_valid;

  logic              cpu_clrn, done, halted, timeout;
  logic [1:0]        state;
  logic [15:0]       cycles;
  logic [DW-1:0]     signature;

  logic              cpu_clrn5, done5, halted5, timeout5;
  logic [1:0]        state5;
  logic [15:0]       cycles5;
  logic [DW-1:0]     signature5;

  cpu_run_monitor dut (
    .Clk(Clk), .Clrn(Clrn), .start(start), .pc(pc), .ch_data(ch_data), .ch_valid(ch_valid),
    .cpu_clrn(cpu_clrn), .state(state), .cycles(cycles), .signature(signature),
    .done(done), .halted(halted), .timeout(timeout)
  );

  cpu_run_monitor #(.MAX_CYCLES(5)) dut5 (
    .Clk(Clk), .Clrn(Clrn), .start(start), .pc(pc), .ch_data(ch_data), .ch_valid(ch_valid),
    .cpu_clrn(cpu_clrn5), .state(state5), .cycles(cycles5), .signature(signature5),
    .done(done5), .halted(halted5), .timeout(timeout5)
  );

  always #5 Clk = ~Clk;

  int cyc = 0;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    int          at;
    string       tag;
    bit [4:0]    m;    // 0 state, 1 cpu_clrn, 2 cycles, 3 signature, 4 flags
    logic [1:0]  st;
    logic        cc;
    logic [15:0] cy;
    logic [31:0] sg;
    logic        d, h, t;
  } exp_t;

  exp_t q[$];
  exp_t dq[$];
  exp_t dq5[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input string fld, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s.%s: got %h expected %h", tag, fld, act, exp);
    end
  endtask

  task automatic compare(input exp_t e, input logic [1:0] st, input logic cc, input logic [15:0] cy,
                         input logic [31:0] sg, input logic d, input logic h, input logic t);
    if (e.m[0]) chk(e.tag, "state", 32'(st), 32'(e.st));
    if (e.m[1]) chk(e.tag, "cpu_clrn", 32'(cc), 32'(e.cc));
    if (e.m[2]) chk(e.tag, "cycles", 32'(cy), 32'(e.cy));
    if (e.m[3]) chk(e.tag, "signature", sg, e.sg);
    if (e.m[4]) chk(e.tag, "done/halted/timeout", {29'd0, d, h, t}, {29'd0, e.d, e.h, e.t});
  endtask

  // qsel 0: checked at the current cycle; 1/2: checked when dut/dut5 raises done
  task automatic push(input int qsel, input string tag, input bit [4:0] m, input logic [1:0] st,
                      input logic cc, input logic [15:0] cy, input logic [31:0] sg,
                      input logic d, input logic h, input logic t);
    exp_t e;
    e.at = cyc; e.tag = tag; e.m = m; e.st = st; e.cc = cc; e.cy = cy; e.sg = sg;
    e.d = d; e.h = h; e.t = t;
    if (qsel == 0) q.push_back(e);
    else if (qsel == 1) dq.push_back(e);
    else dq5.push_back(e);
  endtask

  logic done_prev  = 1'b0;
  logic done5_prev = 1'b0;
  exp_t me;

  // monitor: pops expectations due this cycle and on each rising done
  always @(negedge Clk) begin
    while (q.size() > 0 && q[0].at <= cyc) begin
      me = q.pop_front();
      if (me.at < cyc) chk(me.tag, "missed_sample", 32'(cyc), 32'(me.at));
      else compare(me, state, cpu_clrn, cycles, signature, done, halted, timeout);
    end
    if (done === 1'b1 && done_prev !== 1'b1) begin
      if (dq.size() == 0) chk("unexpected_done", "dq_size", 32'd0, 32'd1);
      else begin
        me = dq.pop_front();
        compare(me, state, cpu_clrn, cycles, signature, done, halted, timeout);
      end
    end
    if (done5 === 1'b1 && done5_prev !== 1'b1) begin
      if (dq5.size() == 0) chk("unexpected_done5", "dq5_size", 32'd0, 32'd1);
      else begin
        me = dq5.pop_front();
        compare(me, state5, cpu_clrn5, cycles5, signature5, done5, halted5, timeout5);
      end
    end
    done_prev  = done;
    done5_prev = done5;
  end

  task automatic tick;
    @(posedge Clk);
    #1;
  endtask

  task automatic begin_run(input string tag);
    start = 1'b1;
    tick;
    start = 1'b0;
    push(0, {tag, "_hold1"}, 5'h1F, 2'd1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    push(0, {tag, "_hold2"}, 5'h03, 2'd1, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    tick;
    push(0, {tag, "_run"}, 5'h03, 2'd2, 1'b1, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
  endtask

  logic [31:0] pcs  [5] = '{32'd0, 32'd4, 32'd8, 32'd8, 32'd8};
  logic [31:0] sigs [5] = '{32'd1, 32'd3, 32'd7, 32'd15, 32'd31};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    Clrn = 1'b1; start = 1'b0; pc = '0; ch_data = '0; ch_valid = '0;
    tick;
    tick;
    push(0, "reset", 5'h1F, 2'd0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    tick;
    push(0, "clrn_over_start", 5'h03, 2'd0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    Clrn = 1'b0; start = 1'b0;

    // halt run: pc 0,4,8,8,8 with channel 0 feeding 1 each cycle
    begin_run("halt");
    ch_valid = 3'b001;
    ch_data  = {32'hDEADBEEF, 32'h12345678, 32'h00000001};
    for (int k = 0; k < 5; k++) begin
      pc = pcs[k];
      tick;
      if (k < 4)
        push(0, $sformatf("halt_c%0d", k + 1), 5'h1F, 2'd2, 1'b1, 16'(k + 1), sigs[k], 1'b0, 1'b0, 1'b0);
    end
    push(1, "halt_done", 5'h1F, 2'd3, 1'b0, 16'd5, 32'd31, 1'b1, 1'b1, 1'b0);
    push(2, "max5_halt_done", 5'h1F, 2'd3, 1'b0, 16'd5, 32'd31, 1'b1, 1'b1, 1'b0);
    pc = 32'd100; ch_valid = 3'b111;
    tick;
    tick;
    push(0, "done_hold", 5'h1F, 2'd3, 1'b0, 16'd5, 32'd31, 1'b1, 1'b1, 1'b0);

    // restart from DONE, pc advancing so only the budget ends the run
    ch_valid = 3'b110;
    ch_data  = {32'h000000A5, 32'h000000A5, 32'hFFFFFFFF};
    begin_run("tmo");
    pc = 32'd0;
    for (int k = 1; k <= 20; k++) begin
      tick;
      pc = pc + 32'd4;
      if (k < 20 && (k % 5) == 0)
        push(0, $sformatf("tmo_c%0d", k), 5'h1F, 2'd2, 1'b1, 16'(k), 32'd0, 1'b0, 1'b0, 1'b0);
      if (k == 5)
        push(2, "max5_tmo_done", 5'h1F, 2'd3, 1'b0, 16'd5, 32'd0, 1'b1, 1'b0, 1'b1);
    end
    push(1, "tmo_done", 5'h1F, 2'd3, 1'b0, 16'd20, 32'd0, 1'b1, 1'b0, 1'b1);

    // mid-run Clrn, with MSB feedback exercised first
    begin_run("clr");
    pc = 32'd0;
    ch_valid = 3'b001;
    ch_data  = {32'h0, 32'h0, 32'h80000000};
    tick;
    push(0, "clr_c1", 5'h1F, 2'd2, 1'b1, 16'd1, 32'h80000000, 1'b0, 1'b0, 1'b0);
    ch_valid = 3'b000;
    pc = 32'd4;
    tick;
    push(0, "clr_c2_poly", 5'h1F, 2'd2, 1'b1, 16'd2, 32'h04C11DB7, 1'b0, 1'b0, 1'b0);
    Clrn = 1'b1;
    pc = 32'd8;
    tick;
    push(0, "clr_midrun", 5'h1F, 2'd0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    Clrn = 1'b0;
    tick;
    push(0, "clr_idle", 5'h1F, 2'd0, 1'b0, 16'd0, 32'd0, 1'b0, 1'b0, 1'b0);

    tick;
    tick;
    while (q.size() > 0)   begin me = q.pop_front();   chk(me.tag, "never_checked", 32'd0, 32'd1); end
    while (dq.size() > 0)  begin me = dq.pop_front();  chk(me.tag, "no_done", 32'd0, 32'd1); end
    while (dq5.size() > 0) begin me = dq5.pop_front(); chk(me.tag, "no_done5", 32'd0, 32'd1); end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
